// File: rtl/hsst_ad_burst_ctrl.sv
// Capture-FIFO burst sequencer: gates the rx write window, waits for full, drains one burst, idles, re-arms.
// Optional FILL watchdog enabled by defining HSST_AD_FILL_TIMEOUT_EN.
module hsst_ad_burst_ctrl #(
  parameter int BURST_LEN   = 256,
  parameter int CNT_W       = 9,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic        err_clr,
  output logic        capture_en,
  output logic        fifo_rd_en,
  output logic        data_valid,
  output logic        burst_done,
  output logic [15:0] burst_cnt,
  output logic        busy,
  output logic        err_underflow,
  output logic        err_timeout
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  if ((2**CNT_W) <= BURST_LEN || GAP_CYC < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("hsst_ad_burst_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             by_en_q, by_en_d;
  logic             capture_en_q, capture_en_d;
  logic             fifo_rd_en_q, fifo_rd_en_d;
  logic             data_valid_q, data_valid_d;
  logic             burst_done_q, burst_done_d;
  logic [15:0]      burst_cnt_q, burst_cnt_d;
  logic             busy_q, busy_d;
  logic             err_underflow_q, err_underflow_d;
  logic             to_hit;

`ifdef HSST_AD_FILL_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_timeout_q, err_timeout_d;
  assign to_hit = (state_q == FILL) && !fifo_full && (wdog_q == 16'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    gap_cnt_d = gap_cnt_q;
    by_en_d   = by_en_q;
    case (state_q)
      IDLE: if (enable || start) begin
        state_d = FILL;
        // a start pulse makes the window single-shot even if enable is also high
        by_en_d = enable & ~start;
      end
      FILL: begin
        if (fifo_full) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
        end else if (to_hit) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else if (by_en_q && !enable) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == RD_LAST) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = enable ? FILL : IDLE;
          by_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they register alongside it
    capture_en_d    = (state_d == FILL);
    fifo_rd_en_d    = (state_d == DRAIN);
    data_valid_d    = fifo_rd_en_q;
    burst_done_d    = (state_q == DRAIN) && (state_d == GAP);
    burst_cnt_d     = burst_cnt_q + 16'(burst_done_d);
    busy_d          = (state_d != IDLE);
    err_underflow_d = (fifo_rd_en_q & fifo_empty) | (err_underflow_q & ~err_clr);
  end

`ifdef HSST_AD_FILL_TIMEOUT_EN
  always_comb begin
    wdog_d        = ((state_q == FILL) && (state_d == FILL)) ? wdog_q + 16'd1 : 16'd0;
    err_timeout_d = to_hit | (err_timeout_q & ~err_clr);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rd_cnt_q        <= '0;
      gap_cnt_q       <= '0;
      by_en_q         <= 1'b0;
      capture_en_q    <= 1'b0;
      fifo_rd_en_q    <= 1'b0;
      data_valid_q    <= 1'b0;
      burst_done_q    <= 1'b0;
      burst_cnt_q     <= '0;
      busy_q          <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      by_en_q         <= by_en_d;
      capture_en_q    <= capture_en_d;
      fifo_rd_en_q    <= fifo_rd_en_d;
      data_valid_q    <= data_valid_d;
      burst_done_q    <= burst_done_d;
      burst_cnt_q     <= burst_cnt_d;
      busy_q          <= busy_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign capture_en    = capture_en_q;
  assign fifo_rd_en    = fifo_rd_en_q;
  assign data_valid    = data_valid_q;
  assign burst_done    = burst_done_q;
  assign burst_cnt     = burst_cnt_q;
  assign busy          = busy_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_hsst_ad_burst_ctrl.sv
// Directed bench for hsst_ad_burst_ctrl: vector table for IDLE/FILL, hand sequences for bursts, errors, reset, watchdog.
module tb_hsst_ad_burst_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0, start = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b0, err_clr = 1'b0;
  logic        capture_en, fifo_rd_en, data_valid, burst_done, busy, err_underflow, err_timeout;
  logic [15:0] burst_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit exp_uf = 1'b0;

  hsst_ad_burst_ctrl #(.BURST_LEN(256), .CNT_W(9), .GAP_CYC(16), .TIMEOUT_CYC(100)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .start(start),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .err_clr(err_clr),
    .capture_en(capture_en), .fifo_rd_en(fifo_rd_en), .data_valid(data_valid),
    .burst_done(burst_done), .burst_cnt(burst_cnt), .busy(busy),
    .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic en, st, full, empty, clr;
    logic [3:0] exp;  // {capture_en, fifo_rd_en, busy, err_underflow}
    string name;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] all_outs();
    return {capture_en, fifo_rd_en, data_valid, burst_done, busy, err_underflow, err_timeout, burst_cnt};
  endfunction

  task automatic apply_reset();
    @(negedge sys_clk) rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk) rst_n = 1'b1;
    exp_uf = 1'b0;
  endtask

  // Hold FILL for n cycles, then present fifo_full and expect the first read cycle.
  task automatic fill_to_drain(input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      fifo_full = 1'b0;
      step();
      if (capture_en !== 1'b1 || fifo_rd_en !== 1'b0) errs++;
    end
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    chk("fill_hold", errs, 0);
    chk("drain_entry {cap,rd}", {capture_en, fifo_rd_en}, 2'b01);
  endtask

  // Called with t=0 being the first sampled fifo_rd_en=1 cycle; checks every cycle through GAP exit.
  task automatic run_burst(input bit refill, input int start_at, input int empty_at, input int clr_at,
                           input logic [15:0] cnt_base);
    int e_rd = 0, e_dv = 0, e_done = 0, e_cap = 0, e_busy = 0, e_cnt = 0, e_uf = 0;
    for (int t = 1; t <= 272; t++) begin
      start      = (t == start_at);
      fifo_empty = (t == empty_at);
      err_clr    = (t == clr_at);
      step();
      // fifo_empty seen at edge t pairs with the read issued during cycle t-1
      if (t == empty_at && t <= 256) exp_uf = 1'b1;
      else if (t == clr_at) exp_uf = 1'b0;
      if (fifo_rd_en !== (t <= 255)) e_rd++;
      if (data_valid !== (t <= 256)) e_dv++;
      if (burst_done !== (t == 256)) e_done++;
      if (capture_en !== (t == 272 && refill)) e_cap++;
      if (busy !== (t < 272 || refill)) e_busy++;
      if (burst_cnt !== ((t >= 256) ? cnt_base + 16'd1 : cnt_base)) e_cnt++;
      if (err_underflow !== exp_uf) e_uf++;
    end
    start = 1'b0; fifo_empty = 1'b0; err_clr = 1'b0;
    chk("burst rd_en wave", e_rd, 0);
    chk("burst data_valid wave", e_dv, 0);
    chk("burst done pulse", e_done, 0);
    chk("burst capture_en wave", e_cap, 0);
    chk("burst busy wave", e_busy, 0);
    chk("burst cnt wave", e_cnt, 0);
    chk("burst underflow wave", e_uf, 0);
  endtask

  initial begin
    int cnt, errs;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "idle quiet"};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, "idle ignores flags"};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, "enable to fill"};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010, "empty without read"};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "enable drop in fill"};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, "start to fill"};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, "start fill holds"};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, "start in fill ignored"};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, "clr in fill"};

    #2 rst_n = 1'b0;
    step(); step();
    chk("reset outputs", all_outs(), 0);
    @(negedge sys_clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en; start = tbl[i].st; fifo_full = tbl[i].full;
      fifo_empty = tbl[i].empty; err_clr = tbl[i].clr;
      step();
      chk(tbl[i].name, {capture_en, fifo_rd_en, busy, err_underflow}, tbl[i].exp);
    end
    enable = 1'b0; start = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0; err_clr = 1'b0;

    // continuous mode burst with re-arm
    apply_reset();
    enable = 1'b1;
    step();
    chk("cont fill entry {cap,busy}", {capture_en, busy}, 2'b11);
    fill_to_drain(40);
    chk("cont cnt before", burst_cnt, 16'd0);
    run_burst(1'b1, -1, -1, -1, 16'd0);

    // fifo_full beats enable falling; then enable stays low through DRAIN
    enable = 1'b0; fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    chk("full wins {cap,rd}", {capture_en, fifo_rd_en}, 2'b01);
    run_burst(1'b0, -1, -1, -1, 16'd1);

    // single shot; second start during DRAIN is dropped
    start = 1'b1;
    step();
    start = 1'b0;
    chk("shot fill entry", capture_en, 1'b1);
    fill_to_drain(5);
    run_burst(1'b0, 50, -1, -1, 16'd2);
    step(); step(); step();
    chk("shot no requeue {busy,cap,rd}", {busy, capture_en, fifo_rd_en}, 3'b000);
    chk("shot cnt", burst_cnt, 16'd3);

    // underflow at read 100, held after the burst
    start = 1'b1; step(); start = 1'b0;
    fill_to_drain(2);
    run_burst(1'b0, -1, 101, -1, 16'd3);
    chk("underflow held", err_underflow, 1'b1);
    // clear together with a new underflow: set wins
    start = 1'b1; step(); start = 1'b0;
    fill_to_drain(2);
    run_burst(1'b0, -1, 51, 51, 16'd4);
    chk("underflow set beats clr", err_underflow, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("underflow clr alone", err_underflow, 1'b0);
    exp_uf = 1'b0;

    // asynchronous reset at read 128
    enable = 1'b1;
    step();
    fill_to_drain(3);
    for (int t = 1; t <= 128; t++) step();
    chk("rd before reset", fifo_rd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", all_outs(), 0);
    @(negedge sys_clk) rst_n = 1'b1;
    step();
    chk("post reset {cap,busy,cnt}", {capture_en, busy, burst_cnt}, {2'b11, 16'd0});

`ifdef HSST_AD_FILL_TIMEOUT_EN
    cnt = 0; errs = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (burst_done !== 1'b0) errs++;
      if (capture_en === 1'b0) begin cnt = i; break; end
    end
    chk("timeout fill cycles", cnt, 100);
    chk("timeout flags {to,busy,rd,done}", {err_timeout, busy, fifo_rd_en, burst_done}, 4'b1100);
    cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (burst_done !== 1'b0) errs++;
      if (capture_en === 1'b1) begin cnt = i; break; end
    end
    chk("timeout gap cycles", cnt, 16);
    chk("timeout no burst_done", errs, 0);
    chk("timeout refill {to,cnt}", {err_timeout, burst_cnt}, {1'b1, 16'd0});
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("timeout clr", err_timeout, 1'b0);
`else
    errs = 0;
    for (int i = 1; i <= 150; i++) begin
      step();
      if (capture_en !== 1'b1 || fifo_rd_en !== 1'b0 || err_timeout !== 1'b0) errs++;
    end
    chk("fill holds without watchdog", errs, 0);
    chk("err_timeout tied low", err_timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hsst_ad_burst_ctrl.md
Name: hsst_ad_burst_ctrl

Overview:
- Sys_clk-domain sequencer for the HSST-to-AD capture FIFO (256 x 8).
- Gates the rx-side write window through `capture_en`, waits for the FIFO to fill, then drains exactly one burst.
- Produces the AD-side `data_valid` strobe and inserts an idle gap before re-arming.
- Supports continuous mode and single-shot mode, burst counting, and sticky error reporting for the AD output path.

Parameters:
- BURST_LEN, 256: words read per burst; must equal FIFO depth.
- CNT_W, 9: width of the read counter; must satisfy 2^CNT_W > BURST_LEN.
- GAP_CYC, 16: idle cycles between bursts; minimum 1.
- TIMEOUT_CYC, 65535: FILL watchdog limit; used only with the optional feature.

Ports:
- sys_clk  in  1  single block clock; FIFO read clock.
- rst_n  in  1  asynchronous reset, active-low.
- enable  in  1  continuous mode; level-sensitive.
- start  in  1  single-shot request; one-cycle pulse.
- fifo_full  in  1  FIFO full flag, already synchronous to sys_clk.
- fifo_empty  in  1  FIFO read-side empty flag.
- err_clr  in  1  clears sticky error flags; pulse.
- capture_en  out  1  write-window gate to the rx-side writer (writer synchronises it).
- fifo_rd_en  out  1  FIFO read enable.
- data_valid  out  1  AD data qualifier; `fifo_rd_en` delayed 1 cycle.
- burst_done  out  1  one-cycle pulse per completed burst.
- burst_cnt  out  16  completed burst count; wraps.
- busy  out  1  high in any state other than IDLE.
- err_underflow  out  1  sticky; a read was attempted while the FIFO was empty.
- err_timeout  out  1  sticky; FILL watchdog expired (constant 0 without the optional feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous; asserting it mid-burst drops `fifo_rd_en`/`capture_en` immediately. No resume after reset.
- All outputs are registered.
- States: IDLE, FILL, DRAIN, GAP.
- IDLE:
  - `enable`=1 or `start`=1 -> FILL; `capture_en`=1 from the next cycle.
- FILL:
  - `capture_en`=1, `fifo_rd_en`=0.
  - `fifo_full`=1 -> DRAIN; `capture_en`=0 and `fifo_rd_en`=1 on the following cycle.
  - `enable` falls while the cycle was entered by `enable` (not by `start`) -> IDLE, `capture_en`=0 next cycle.
  - If `fifo_full` and `enable` fall in the same cycle, `fifo_full` wins (go to DRAIN).
- DRAIN:
  - `fifo_rd_en`=1 for exactly BURST_LEN consecutive cycles.
  - `rd_cnt` counts 0..BURST_LEN-1; at BURST_LEN-1 the next state is GAP and `fifo_rd_en`=0.
  - `enable`/`start` changes are ignored; the burst always completes.
  - `fifo_empty`=1 in any cycle with `fifo_rd_en`=1 sets `err_underflow`; the count continues, no abort.
- GAP:
  - Lasts GAP_CYC cycles with `capture_en`=0 and `fifo_rd_en`=0.
  - `burst_done`=1 on the first GAP cycle, coinciding with the last `data_valid`.
  - `burst_cnt` increments on that same cycle; 0xFFFF -> 0x0000.
  - At the end of GAP: `enable`=1 -> FILL, else IDLE.
- `start` outside IDLE is ignored (not queued).
- `data_valid`: exactly BURST_LEN contiguous cycles per burst, 1 cycle after `fifo_rd_en`.
- Sticky flags:
  - Cleared by `err_clr`.
  - If set and `err_clr` occur in the same cycle, set wins.
- `busy` = (state != IDLE), registered with the state.

Optional Feature:
- Macro: HSST_AD_FILL_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in FILL.
  - On reaching TIMEOUT_CYC without `fifo_full`: set `err_timeout`, drop `capture_en`, go to GAP (no `burst_done`, `burst_cnt` unchanged), then follow the normal GAP exit rule.
  - The watchdog clears on every FILL entry.
- Undefined: no watchdog logic; `err_timeout` tied to 0; FILL waits indefinitely.

Test Plan:
- Reset, then `enable`=1; `fifo_full` asserts 40 cycles after `capture_en` -> `fifo_rd_en` high for 256 cycles, `data_valid` 256 cycles lagging by 1, `burst_done` pulse, `burst_cnt`=1, 16 idle cycles, `capture_en` re-asserts.
- `enable`=0, `start` pulse; a second `start` during DRAIN -> exactly one burst, then IDLE, `busy`=0, `burst_cnt`=1.
- `enable` dropped in FILL (no `start`) -> IDLE next cycle, `capture_en`=0, no read. `enable` dropped mid-DRAIN -> all 256 reads complete, then IDLE.
- `fifo_empty` forced high at read 100 -> `err_underflow`=1 and held after the burst. `err_clr` together with a new underflow -> stays 1. `err_clr` alone -> 0.
- `rst_n` low at read 128 -> all outputs 0 immediately. After release with `enable`=1 -> new FILL, `burst_cnt`=0.
- With HSST_AD_FILL_TIMEOUT_EN, TIMEOUT_CYC=100, `fifo_full` never asserts -> `err_timeout`=1 after 100 FILL cycles, `capture_en`=0, no `burst_done`, re-enters FILL after GAP. Without the macro -> FILL holds, `err_timeout`=0.
